// File: rtl/reset_sequencer_if.sv
// Reset sequencer board-side bundle: pushbutton and watchdog service in,
// sequenced resets, status and FSM state out.
interface reset_sequencer_if #(
    parameter int N_OUT = 3
);
    logic             key_n;
    logic             wdt_kick;
    logic [N_OUT-1:0] rst_out_n;
    logic             seq_done;
    logic [1:0]       reset_cause;
    logic             heartbeat;
    logic [1:0]       seq_state;

    modport master (
        input  key_n, wdt_kick,
        output rst_out_n, seq_done, reset_cause, heartbeat, seq_state
    );

    modport slave (
        output key_n, wdt_kick,
        input  rst_out_n, seq_done, reset_cause, heartbeat, seq_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Board reset manager: key synchroniser + debounce, hold-off, staged release of
// N_OUT active-low resets, heartbeat and reset cause. Watchdog: RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
    parameter int N_OUT           = 3,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 8,
    parameter int HB_BITS         = 24,
    parameter int WDT_CYCLES      = 1048576
) (
    input  logic                clk,
    input  logic                rst_n,
    reset_sequencer_if.master   bus
);
    localparam int REL_MAX = (N_OUT - 1) * STAGE_GAP;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int REL_W   = $clog2(REL_MAX + 1) + 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;
    logic                   key_db;
    logic [DEB_W-1:0]       deb_cnt;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REL_W-1:0]   rel_q, rel_d, rel_next;
    logic [N_OUT-1:0]   rst_q, rst_d;
    logic               done_q, done_d;
    logic [1:0]         cause_q, cause_d;
    logic [HB_BITS-1:0] hb_cnt;
    logic               release_now;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
    logic [WDT_W-1:0] wdt_q, wdt_d;
`else
    logic unused_wdt;
    assign unused_wdt = bus.wdt_kick ^ (WDT_CYCLES == 0);
`endif

    assign key_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            key_db  <= 1'b1;
            deb_cnt <= '0;
            hb_cnt  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_n};
            hb_cnt <= hb_cnt + 1'b1;
            // Any sample agreeing with the accepted state restarts the run.
            if (key_s == key_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db  <= key_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            rel_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 2'b00;
`ifdef RESET_SEQ_WATCHDOG_EN
            wdt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rel_q   <= rel_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            cause_q <= cause_d;
`ifdef RESET_SEQ_WATCHDOG_EN
            wdt_q   <= wdt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        rel_d       = rel_q;
        rst_d       = rst_q;
        done_d      = done_q;
        cause_d     = cause_q;
        rel_next    = '0;
        release_now = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        wdt_d       = wdt_q;
`endif
        case (state_q)
            ST_ASSERT: begin
                rst_d  = '0;
                done_d = 1'b0;
                if (key_db) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    release_now = 1'b1;
                    rel_next    = '0;
                end
            end
            ST_RELEASE: begin
                release_now = 1'b1;
                rel_next    = rel_q + 1'b1;
            end
            ST_RUN: begin
`ifdef RESET_SEQ_WATCHDOG_EN
                if (bus.wdt_kick) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    state_d = ST_ASSERT;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    cause_d = 2'b10;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_ASSERT;
        endcase

        // rel_next counts cycles since HOLD exit; bit k is due at k*STAGE_GAP.
        if (release_now) begin
            rel_d = rel_next;
            for (int k = 0; k < N_OUT; k++) begin
                rst_d[k] = (int'(rel_next) >= k * STAGE_GAP);
            end
            if (int'(rel_next) == REL_MAX) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
`ifdef RESET_SEQ_WATCHDOG_EN
                wdt_d   = '0;
`endif
            end else begin
                state_d = ST_RELEASE;
            end
        end

        // A debounced press overrides everything, including a watchdog expiry.
        if (state_q != ST_ASSERT && !key_db) begin
            state_d = ST_ASSERT;
            rst_d   = '0;
            done_d  = 1'b0;
            cause_d = 2'b01;
            hold_d  = '0;
            rel_d   = '0;
        end
    end

    assign bus.rst_out_n   = rst_q;
    assign bus.seq_done    = done_q;
    assign bus.reset_cause = cause_q;
    assign bus.heartbeat   = hb_cnt[HB_BITS-1];
    assign bus.seq_state   = state_q;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Board-level reset manager that sits between the FPGA top level and the core(s).
- Successor to a fixed 3-flop key synchroniser plus free-running LED counter. Generalised to N independently released reset outputs, with configurable synchroniser depth, pushbutton debounce, hold-off stretch and staged release.
- Also provides a heartbeat output and a reset-cause register.
- Drives the active-low reset of every downstream block.

Parameters:
- N_OUT, 3: number of sequenced reset outputs (1..16).
- SYNC_STAGES, 3: flops in the key_n synchroniser (>=2).
- DEBOUNCE_CYCLES, 16: consecutive equal synchronised samples needed to accept a key change (>=1).
- HOLD_CYCLES, 1024: cycles all outputs stay asserted after a reset source clears (>=1).
- STAGE_GAP, 8: cycles between release of rst_out_n[k] and rst_out_n[k+1] (>=1).
- HB_BITS, 24: heartbeat counter width. Heartbeat period is 2^HB_BITS cycles.
- WDT_CYCLES, 1048576: watchdog timeout in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset (power-on / PLL lock).
- key_n  in  1  raw asynchronous pushbutton, low = pressed.
- wdt_kick  in  1  single-cycle watchdog service pulse. Ignored unless the optional feature is built.
- rst_out_n  out  N_OUT  sequenced active-low resets. Bit 0 is released first.
- seq_done  out  1  high once all rst_out_n are released.
- reset_cause  out  2  last reset source: 00 power-on, 01 key, 10 watchdog, 11 unused.
- heartbeat  out  1  MSB of the free-running counter.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
- rst_n low gives, immediately and asynchronously:
  - rst_out_n = 0
  - seq_done = 0
  - heartbeat = 0 and heartbeat counter = 0
  - reset_cause = 00
  - synchroniser flops and debounced key state = 1 (released)
  - state = HOLD, all counters = 0
- Synchroniser: key_n passes through SYNC_STAGES flops before any use.
- Debounce: the debounced key state changes only after DEBOUNCE_CYCLES consecutive synchronised samples that differ from it. Any sample equal to the current state clears the count.
- States:
  - ASSERT: all rst_out_n = 0, seq_done = 0. Stay while the debounced key is pressed. Go to HOLD on the first cycle it is released.
  - HOLD: all rst_out_n = 0. Count HOLD_CYCLES cycles, then go to RELEASE.
  - RELEASE: rst_out_n[k] goes to 1 at HOLD-exit + k*STAGE_GAP. seq_done goes to 1 on the same edge as rst_out_n[N_OUT-1]. Then go to RUN.
  - RUN: all outputs 1. Stay until a reset event.
- Release timing: first rising clk edge with rst_n high is cycle 1. rst_out_n[k] rises at cycle HOLD_CYCLES + k*STAGE_GAP.
- Key press event: debounced key goes 1->0.
  - From any of HOLD, RELEASE or RUN, go to ASSERT on the next edge.
  - All rst_out_n and seq_done go low on that edge.
  - reset_cause is set to 01 on the same edge.
  - A press during HOLD or RELEASE restarts the whole sequence.
- Key response latency: rst_out_n drops no later than SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after key_n falls.
- Glitch rejection: any low pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation has no effect.
- Simultaneous key press and watchdog expiry: key wins, reset_cause = 01.
- reset_cause holds its value through HOLD, RELEASE and RUN. Only a new event or rst_n changes it.
- Heartbeat counter:
  - Increments every cycle in every state and wraps modulo 2^HB_BITS.
  - Only rst_n clears it; key and watchdog resets do not.
- Outputs: all registered. rst_out_n never glitches, since every bit comes straight from a flop.
- Counters: sized to $clog2 of their terminal value plus 1. No wrap is possible inside HOLD or RELEASE.

Optional Feature:
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - A watchdog counter runs only in RUN and is cleared when entering RUN and on every cycle with wdt_kick = 1.
  - On the edge where the count reaches WDT_CYCLES, go to ASSERT: rst_out_n = 0, seq_done = 0, reset_cause = 10.
  - Next cycle the key is released, so the FSM goes to HOLD and the normal sequence follows.
  - wdt_kick outside RUN is ignored.
- Undefined:
  - No watchdog counter is synthesised.
  - wdt_kick is unconnected internally.
  - reset_cause never takes the value 10.

Test Plan:
All tests use N_OUT=3, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, STAGE_GAP=3, HB_BITS=4.
- Power-on: rst_n low 5 cycles then high, key_n=1 -> rst_out_n = 000 through cycle 9; 001 at cycle 10, 011 at 13, 111 at 16; seq_done=1 at 16; reset_cause=00.
- Key press in RUN: key_n low 20 cycles -> rst_out_n drops to 000 within 8 cycles of key_n falling, reset_cause=01. After release is debounced, outputs restart the 10/13/16 cycle release pattern.
- Glitch: key_n low for 2 cycles in RUN -> rst_out_n stays 111 and reset_cause is unchanged.
- Mid-sequence restart: debounced press at cycle 12 (rst_out_n=001) -> all outputs drop to 000 and the full HOLD restarts from zero after release.
- Async reset in RUN: rst_n pulled low between clock edges -> all outputs at reset values before the next edge. Heartbeat toggles every 8 cycles after release.
- Watchdog (RESET_SEQ_WATCHDOG_EN, WDT_CYCLES=20): no kick for 20 cycles in RUN -> rst_out_n=000 and reset_cause=10. Kicking every 10 cycles -> no reset for 500 cycles.
